// File: rtl/rx_char_framer.sv
// Receive character framer: hunts for a NULL, then decodes control, data and time-code characters.
// Define RX_PARITY_CHECK_EN to enable the parity check and the parity_error_rx pulse.
module rx_char_framer (
    input  logic       pclk_rx,
    input  logic       reset_rx,
    input  logic       enable_rx,
    input  logic       bit_valid_rx,
    input  logic       bit_rx,
    output logic       got_null_rx,
    output logic       got_fct_rx,
    output logic       got_eop_rx,
    output logic       got_eep_rx,
    output logic       got_data_rx,
    output logic       got_time_code_rx,
    output logic [7:0] data_rx,
    output logic [7:0] time_code_rx,
    output logic       parity_error_rx,
    output logic       esc_error_rx,
    output logic       first_null_rx
);

    localparam logic [1:0] RX_HUNT = 2'd0;
    localparam logic [1:0] RX_HEAD = 2'd1;
    localparam logic [1:0] RX_CTRL = 2'd2;
    localparam logic [1:0] RX_DATA = 2'd3;

`ifdef RX_PARITY_CHECK_EN
    localparam logic PAR_CHK = 1'b1;
`else
    localparam logic PAR_CHK = 1'b0;
`endif

    // Newest seven bits of a NULL; the oldest bit is the previous character's parity.
    localparam logic [6:0] NULL_PAT = 7'b1110100;

    logic [1:0] state_q, state_d;
    logic [7:0] win_q, win_d;
    logic [9:0] cnt_q, cnt_d;
    logic       par_q, par_d;
    logic       p_q, p_d;
    logic [7:0] sh_q, sh_d;
    logic       esc_q, esc_d;
    logic [5:0] pul_q, pul_d;   // {null, fct, eop, eep, data, time_code}
    logic       perr_q, perr_d;
    logic       eerr_q, eerr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] tc_q, tc_d;
    logic       first_q, first_d;
    logic       abort;

    logic [7:0] win_shift, sh_shift;
    logic [9:0] cnt_shift;
    logic       par_fail;

    assign win_shift = {win_q[6:0], bit_rx};
    assign sh_shift  = {bit_rx, sh_q[7:1]};
    assign cnt_shift = {cnt_q[8:0], 1'b0};
    assign par_fail  = PAR_CHK & ~(par_q ^ p_q ^ bit_rx);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        p_d     = p_q;
        sh_d    = sh_q;
        esc_d   = esc_q;
        data_d  = data_q;
        tc_d    = tc_q;
        first_d = first_q;
        pul_d   = '0;
        perr_d  = 1'b0;
        eerr_d  = 1'b0;
        abort   = 1'b0;
        if (!enable_rx) begin
            abort = 1'b1;
        end else if (bit_valid_rx) begin
            case (state_q)
                RX_HUNT: begin
                    win_d = win_shift;
                    if (win_shift[6:0] == NULL_PAT) begin
                        pul_d[5] = 1'b1;
                        first_d  = 1'b1;
                        par_d    = 1'b0;
                        win_d    = '0;
                        cnt_d    = 10'd1;
                        state_d  = RX_HEAD;
                    end
                end
                RX_HEAD: begin
                    cnt_d = cnt_shift;
                    if (cnt_q[0]) begin
                        p_d = bit_rx;
                    end else if (par_fail) begin
                        perr_d = 1'b1;
                        abort  = 1'b1;
                    end else begin
                        state_d = bit_rx ? RX_CTRL : RX_DATA;
                    end
                end
                RX_CTRL: begin
                    cnt_d = cnt_shift;
                    sh_d  = sh_shift;
                    // Control code is {second bit, first bit}, sitting in sh_shift[7:6].
                    if (cnt_q[3]) begin
                        cnt_d   = 10'd1;
                        par_d   = ^sh_shift[7:6];
                        state_d = RX_HEAD;
                        esc_d   = 1'b0;
                        if (esc_q && sh_shift[7:6] != 2'b00) begin
                            eerr_d = 1'b1;
                            abort  = 1'b1;
                        end else begin
                            case (sh_shift[7:6])
                                2'b00: begin
                                    if (esc_q) begin
                                        pul_d[5] = 1'b1;
                                        first_d  = 1'b1;
                                    end else begin
                                        pul_d[4] = 1'b1;
                                    end
                                end
                                2'b01:   pul_d[3] = 1'b1;
                                2'b10:   pul_d[2] = 1'b1;
                                default: esc_d    = 1'b1;
                            endcase
                        end
                    end
                end
                default: begin
                    cnt_d = cnt_shift;
                    sh_d  = sh_shift;
                    if (cnt_q[9]) begin
                        cnt_d   = 10'd1;
                        par_d   = ^sh_shift;
                        state_d = RX_HEAD;
                        esc_d   = 1'b0;
                        if (esc_q) begin
                            pul_d[0] = 1'b1;
                            tc_d     = sh_shift;
                        end else begin
                            pul_d[1] = 1'b1;
                            data_d   = sh_shift;
                        end
                    end
                end
            endcase
        end
        if (abort) begin
            state_d = RX_HUNT;
            win_d   = '0;
            esc_d   = 1'b0;
            first_d = 1'b0;
            cnt_d   = 10'd1;
        end
    end

    always_ff @(posedge pclk_rx) begin
        if (reset_rx) begin
            state_q <= RX_HUNT;
            win_q   <= '0;
            cnt_q   <= 10'd1;
            par_q   <= 1'b0;
            p_q     <= 1'b0;
            sh_q    <= '0;
            esc_q   <= 1'b0;
            pul_q   <= '0;
            perr_q  <= 1'b0;
            eerr_q  <= 1'b0;
            data_q  <= '0;
            tc_q    <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            p_q     <= p_d;
            sh_q    <= sh_d;
            esc_q   <= esc_d;
            pul_q   <= pul_d;
            perr_q  <= perr_d;
            eerr_q  <= eerr_d;
            data_q  <= data_d;
            tc_q    <= tc_d;
            first_q <= first_d;
        end
    end

    assign got_null_rx      = pul_q[5];
    assign got_fct_rx       = pul_q[4];
    assign got_eop_rx       = pul_q[3];
    assign got_eep_rx       = pul_q[2];
    assign got_data_rx      = pul_q[1];
    assign got_time_code_rx = pul_q[0];
    assign data_rx          = data_q;
    assign time_code_rx     = tc_q;
    assign parity_error_rx  = perr_q;
    assign esc_error_rx     = eerr_q;
    assign first_null_rx    = first_q;

endmodule

// File: tb/tb_rx_char_framer.sv
// Self-checking bench for rx_char_framer: character table plus hand-written gap/enable/reset sequences.
module tb_rx_char_framer;

    logic       clk = 1'b0;
    logic       reset_rx, enable_rx, bit_valid_rx, bit_rx;
    logic       got_null_rx, got_fct_rx, got_eop_rx, got_eep_rx, got_data_rx, got_time_code_rx;
    logic [7:0] data_rx, time_code_rx;
    logic       parity_error_rx, esc_error_rx, first_null_rx;

    always #5 clk = ~clk;

    rx_char_framer dut (
        .pclk_rx(clk), .reset_rx(reset_rx), .enable_rx(enable_rx),
        .bit_valid_rx(bit_valid_rx), .bit_rx(bit_rx),
        .got_null_rx(got_null_rx), .got_fct_rx(got_fct_rx), .got_eop_rx(got_eop_rx),
        .got_eep_rx(got_eep_rx), .got_data_rx(got_data_rx), .got_time_code_rx(got_time_code_rx),
        .data_rx(data_rx), .time_code_rx(time_code_rx),
        .parity_error_rx(parity_error_rx), .esc_error_rx(esc_error_rx),
        .first_null_rx(first_null_rx)
    );

    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_NULL = 6'b100000;
    localparam logic [5:0] P_FCT  = 6'b010000;
    localparam logic [5:0] P_EOP  = 6'b001000;
    localparam logic [5:0] P_EEP  = 6'b000100;
    localparam logic [5:0] P_DATA = 6'b000010;
    localparam logic [5:0] P_TC   = 6'b000001;
    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_PAR  = 2'b10;
    localparam logic [1:0] E_ESC  = 2'b01;

    typedef struct {
        string       nm;
        logic [11:0] bits;   // wire order, bits[0] sent first
        int unsigned n;
        logic [5:0]  pul;
        logic [1:0]  err;
        logic        first;
        logic [7:0]  pay;
    } vec_t;

    typedef struct {
        string       nm;
        logic [24:0] val;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   passed = 0;
    int   total  = 0;
    logic acc = 1'b0;          // model of the running parity accumulator
    logic       cur_first = 1'b0;
    logic [7:0] cur_dat   = 8'h00;
    logic [7:0] cur_tc    = 8'h00;

    logic [24:0] obs;
    assign obs = {got_null_rx, got_fct_rx, got_eop_rx, got_eep_rx, got_data_rx, got_time_code_rx,
                  parity_error_rx, esc_error_rx, first_null_rx, data_rx, time_code_rx};

    function automatic logic [24:0] pack(input logic [5:0] pul, input logic [1:0] err,
                                         input logic first, input logic [7:0] d, input logic [7:0] t);
        return {pul, err, first, d, t};
    endfunction

    task automatic tick(input logic rst, input logic en, input logic v, input logic b,
                        input string nm, input logic [24:0] expv);
        sb_t e;
        reset_rx = rst; enable_rx = en; bit_valid_rx = v; bit_rx = b;
        sb.push_back('{nm, expv});
        @(posedge clk);
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got %h", nm, obs);
        end else begin
            e = sb.pop_front();
            if (obs !== e.val) $display("FAIL %s: got %h expected %h", e.nm, obs, e.val);
            else passed++;
        end
    endtask

    task automatic send_char(input logic [11:0] bits, input int unsigned n, input bit gap,
                             input string nm, input logic [5:0] pul, input logic [1:0] err,
                             input logic first_after, input logic [7:0] pay);
        for (int unsigned i = 0; i < n; i++) begin
            if (i == n - 1) begin
                if (pul == P_DATA) cur_dat = pay;
                if (pul == P_TC) cur_tc = pay;
                cur_first = first_after;
                tick(1'b0, 1'b1, 1'b1, bits[i], nm, pack(pul, err, cur_first, cur_dat, cur_tc));
            end else begin
                tick(1'b0, 1'b1, 1'b1, bits[i], nm, pack(P_NONE, E_NONE, cur_first, cur_dat, cur_tc));
                if (gap)
                    tick(1'b0, 1'b1, 1'b0, ~bits[i], {nm, "_gap"},
                         pack(P_NONE, E_NONE, cur_first, cur_dat, cur_tc));
            end
        end
    endtask

    task automatic add_null(input string nm, input logic x);
        logic [11:0] b;
        b = {4'h0, 8'b0010_1110};
        b[0] = x;
        tbl.push_back('{nm, b, 8, P_NULL, E_NONE, 1'b1, 8'h00});
        acc = 1'b0;
    endtask

    task automatic add_data(input string nm, input logic [7:0] d, input logic badp,
                            input logic [5:0] pul, input logic [1:0] err, input logic first);
        logic p;
        p = ~acc ^ badp;
        tbl.push_back('{nm, {2'b00, d, 1'b0, p}, 10, pul, err, first, d});
        acc = ^d;
    endtask

    task automatic add_ctrl(input string nm, input logic [1:0] v, input logic badp,
                            input logic [5:0] pul, input logic [1:0] err, input logic first);
        logic p;
        p = acc ^ badp;
        tbl.push_back('{nm, {8'h00, v, 1'b1, p}, 4, pul, err, first, 8'h00});
        acc = ^v;
    endtask

    task automatic run_tbl(input bit gap);
        for (int i = 0; i < tbl.size(); i++)
            send_char(tbl[i].bits, tbl[i].n, gap, tbl[i].nm, tbl[i].pul, tbl[i].err,
                      tbl[i].first, tbl[i].pay);
        tbl.delete();
    endtask

    initial begin
        reset_rx = 1'b1; enable_rx = 1'b0; bit_valid_rx = 1'b0; bit_rx = 1'b0;
        tick(1'b1, 1'b1, 1'b1, 1'b1, "reset0", pack(P_NONE, E_NONE, 1'b0, 8'h00, 8'h00));
        tick(1'b1, 1'b1, 1'b0, 1'b0, "reset1", pack(P_NONE, E_NONE, 1'b0, 8'h00, 8'h00));

        add_null("null1", 1'b0);
        add_data("data_a5", 8'hA5, 1'b0, P_DATA, E_NONE, 1'b1);
        add_ctrl("fct",  2'b00, 1'b0, P_FCT, E_NONE, 1'b1);
        add_ctrl("eop",  2'b01, 1'b0, P_EOP, E_NONE, 1'b1);
        add_ctrl("eep",  2'b10, 1'b0, P_EEP, E_NONE, 1'b1);
        add_ctrl("esc1", 2'b11, 1'b0, P_NONE, E_NONE, 1'b1);
        add_data("tc_3f", 8'h3F, 1'b0, P_TC, E_NONE, 1'b1);
        add_ctrl("esc2", 2'b11, 1'b0, P_NONE, E_NONE, 1'b1);
        add_ctrl("esc_fct", 2'b00, 1'b0, P_NULL, E_NONE, 1'b1);
        add_data("data_5c", 8'h5C, 1'b0, P_DATA, E_NONE, 1'b1);
        add_ctrl("esc3", 2'b11, 1'b0, P_NONE, E_NONE, 1'b1);
        add_ctrl("esc_eop", 2'b01, 1'b0, P_NONE, E_ESC, 1'b0);
        add_ctrl("fct_in_hunt", 2'b00, 1'b0, P_NONE, E_NONE, 1'b0);
        add_null("null2", 1'b0);
`ifdef RX_PARITY_CHECK_EN
        add_ctrl("fct_badp", 2'b00, 1'b1, P_NONE, E_PAR, 1'b0);
`else
        add_ctrl("fct_badp", 2'b00, 1'b1, P_FCT, E_NONE, 1'b1);
`endif
        add_null("null3", 1'b0);
        add_ctrl("esc4", 2'b11, 1'b0, P_NONE, E_NONE, 1'b1);
        add_ctrl("esc_esc", 2'b11, 1'b0, P_NONE, E_ESC, 1'b0);
        add_null("null4", 1'b0);
        add_ctrl("esc5", 2'b11, 1'b0, P_NONE, E_NONE, 1'b1);
        add_ctrl("esc_eep", 2'b10, 1'b0, P_NONE, E_ESC, 1'b0);
        add_null("null5", 1'b0);
        add_data("data_00", 8'h00, 1'b0, P_DATA, E_NONE, 1'b1);
        add_data("data_ff", 8'hFF, 1'b0, P_DATA, E_NONE, 1'b1);
        run_tbl(1'b0);

        // Idle cycles between accepted bits must not disturb decoding.
        add_data("data_96_gaps", 8'h96, 1'b0, P_DATA, E_NONE, 1'b1);
        run_tbl(1'b1);

        // ESC pending, partial data char, then enable drop: everything discarded.
        add_ctrl("esc_pre", 2'b11, 1'b0, P_NONE, E_NONE, 1'b1);
        run_tbl(1'b0);
        send_char(12'h005, 4, 1'b0, "partial", P_NONE, E_NONE, 1'b1, 8'h00);
        cur_first = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b1, "en_low0", pack(P_NONE, E_NONE, 1'b0, cur_dat, cur_tc));
        tick(1'b0, 1'b0, 1'b1, 1'b0, "en_low1", pack(P_NONE, E_NONE, 1'b0, cur_dat, cur_tc));
        add_null("null_en", 1'b0);
        add_ctrl("fct_after_en", 2'b00, 1'b0, P_FCT, E_NONE, 1'b1);
        add_data("data_22", 8'h22, 1'b0, P_DATA, E_NONE, 1'b1);
        run_tbl(1'b0);

        // Reset after five payload bits, then a NULL whose leading bit is 1.
        send_char(12'h07D, 7, 1'b0, "partial_rst", P_NONE, E_NONE, 1'b1, 8'h00);
        cur_first = 1'b0; cur_dat = 8'h00; cur_tc = 8'h00;
        tick(1'b1, 1'b1, 1'b1, 1'b1, "reset_mid", pack(P_NONE, E_NONE, 1'b0, 8'h00, 8'h00));
        add_null("null_x1", 1'b1);
        add_data("data_3c", 8'h3C, 1'b0, P_DATA, E_NONE, 1'b1);
        run_tbl(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rx_char_framer.md
RX_CHAR_FRAMER -- requirements
Module: rx_char_framer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: pclk_rx  in  1  receive clock, all state updates on its rising edge.
REQ-002 reset_rx  in  1  synchronous active-high reset.
REQ-003 enable_rx  in  1  link receive enable; low forces the hunt state synchronously.
REQ-004 bit_valid_rx  in  1  strobe; bit_rx is consumed only in cycles where it is high.
REQ-005 bit_rx  in  1  decoded serial bit, in wire order: parity, control flag, then LSB-first payload.
REQ-006 got_null_rx, got_fct_rx, got_eop_rx, got_eep_rx, got_data_rx, got_time_code_rx  out  1 each  single-cycle character pulses.
REQ-007 data_rx  out  8  last data character payload; time_code_rx  out  8  last time-code payload.
REQ-008 parity_error_rx, esc_error_rx  out  1 each  single-cycle error pulses.
REQ-009 first_null_rx  out  1  level, high once the framer has aligned on a NULL.

Function
REQ-010 States: RX_HUNT, RX_HEAD, RX_CTRL, RX_DATA.
- RX_HUNT: 8-bit sliding window of accepted bits; a match requires oldest-first bit pattern x,1,1,1,0,1,0,0. On a match: got_null_rx pulses, first_null_rx is set, parity accumulator is cleared to 0, and the state goes to RX_HEAD.
REQ-011 RX_HEAD collects 2 bits (P, C).
- Parity check: accumulator XOR P XOR C SHALL equal 1.
- Next state: C=1 goes to RX_CTRL; C=0 goes to RX_DATA.
REQ-012 RX_CTRL collects 2 bits: 00=FCT, 01=EOP, 10=EEP, 11=ESC (value = {second bit, first bit}).
REQ-013 RX_DATA collects 8 bits LSB-first.
REQ-014 Bit position SHALL be tracked by a one-hot 10-bit counter that is shifted left on each accepted bit and reloaded to 1 at every character boundary; no binary counter is used.
REQ-015 The parity accumulator SHALL be reloaded at every character end with the XOR of that character's payload bits.
REQ-016 ESC SHALL set an escape-pending flag and produce no pulse.
- ESC then FCT: got_null_rx (not got_fct_rx).
- ESC then data: got_time_code_rx, with time_code_rx loaded.
- ESC then EOP, EEP or ESC: esc_error_rx.
- The flag clears after the following character.
REQ-017 Character pulses and data_rx/time_code_rx SHALL update in the cycle after the clock edge that samples the character's final bit (latency 1); data_rx and time_code_rx hold between updates.
REQ-018 At most one character pulse SHALL be high per cycle; bits without bit_valid_rx leave all state unchanged.
REQ-019 Any error pulse SHALL clear first_null_rx, discard the character in progress, and return the state to RX_HUNT with the hunt window cleared.
REQ-020 enable_rx low SHALL override bit_valid_rx: RX_HUNT, window cleared, escape-pending cleared, first_null_rx low, no pulses.
REQ-021 Outside RX_HUNT the window is not evaluated; a NULL is recognised only via ESC+FCT.

Reset
REQ-022 reset_rx SHALL set the state to RX_HUNT and clear to 0: window, one-hot counter (loaded to 1), parity accumulator, escape-pending, all pulses, data_rx, time_code_rx, first_null_rx.
REQ-023 Reset asserted mid-character SHALL discard all partial bits, with no pulse emitted.

Configuration
REQ-024 Macro RX_PARITY_CHECK_EN defined: the REQ-011 check is active, a failure pulses parity_error_rx and follows REQ-019, and no character pulse is emitted for that character.
REQ-025 Macro RX_PARITY_CHECK_EN undefined: parity_error_rx is tied to 0, and characters are decoded and delivered regardless of P.

Verification
REQ-026 Reset, enable_rx=1, bits 0,1,1,1,0,1,0,0 -> got_null_rx 1 cycle after the 8th bit, first_null_rx=1.
REQ-027 After NULL, data 0xA5 with correct parity (P=1, C=0, bits 1,0,1,0,0,1,0,1) -> got_data_rx pulse, data_rx=0xA5.
REQ-028 After NULL, ESC then data 0x3F -> got_time_code_rx, time_code_rx=0x3F, no got_data_rx.
REQ-029 After NULL, ESC then EOP -> esc_error_rx pulse, first_null_rx=0, a further FCT yields no got_fct_rx until a new NULL is received.
REQ-030 With RX_PARITY_CHECK_EN, FCT with wrong P -> parity_error_rx, no got_fct_rx; without the macro -> got_fct_rx.
REQ-031 reset_rx pulsed after 5 data bits, then a new NULL -> no stale pulse, got_null_rx on the new NULL only.
